// File: rtl/ibex_multdiv_imd_wb_buffer.sv
// Intermediate-value registers and result FIFO between ibex_multdiv_fast and writeback.
// Define MULTDIV_IMD_PARITY_EN to add even parity on the imd registers and imd_parity_err_o.
module ibex_multdiv_imd_wb_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IMD_W = 34,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [1:0][IMD_W-1:0] imd_val_d_i,
  input  logic [1:0]            imd_val_we_i,
  output logic [1:0][IMD_W-1:0] imd_val_q_o,
  input  logic                  multdiv_valid_i,
  input  logic [31:0]           multdiv_result_i,
  input  logic [4:0]            multdiv_rd_i,
  output logic                  multdiv_ready_id_o,
  output logic                  wb_valid_o,
  output logic [31:0]           wb_data_o,
  output logic [4:0]            wb_rd_o,
  input  logic                  wb_ready_i,
  output logic [CW-1:0]         count_o
`ifdef MULTDIV_IMD_PARITY_EN
  ,
  output logic                  imd_parity_err_o
`endif
);

  logic [1:0][IMD_W-1:0] r_imd;
  logic [DEPTH-1:0][31:0] r_data;
  logic [DEPTH-1:0][4:0]  r_rd;
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Intermediate registers: flush wins over any same-cycle write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_imd <= '0;
    end else if (flush_i) begin
      r_imd <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (imd_val_we_i[k]) begin
          r_imd[k] <= imd_val_d_i[k];
        end
      end
    end
  end

  assign imd_val_q_o = r_imd;

`ifdef MULTDIV_IMD_PARITY_EN
  logic [1:0] r_par;
  logic       r_par_err;
  logic       w_par_mismatch;

  always_comb begin
    w_par_mismatch = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w_par_mismatch = w_par_mismatch | ((^r_imd[k]) != r_par[k]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_par     <= '0;
      r_par_err <= 1'b0;
    end else if (flush_i) begin
      r_par     <= '0;
      r_par_err <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (imd_val_we_i[k]) begin
          r_par[k] <= ^imd_val_d_i[k];
        end
      end
      r_par_err <= w_par_mismatch;
    end
  end

  assign imd_parity_err_o = r_par_err;
`endif

  // Full/empty come from the occupancy counter; pointers alone are ambiguous.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = multdiv_valid_i & ~w_full & ~flush_i;
  assign w_pop   = ~w_empty & wb_ready_i & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_rd    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= multdiv_result_i;
        r_rd[r_wptr]   <= multdiv_rd_i;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign multdiv_ready_id_o = ~w_full;
  assign wb_valid_o         = ~w_empty;
  assign wb_data_o          = w_empty ? 32'h0 : r_data[r_rptr];
  assign wb_rd_o            = w_empty ? 5'h0 : r_rd[r_rptr];
  assign count_o            = r_count;

  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    r_count <= CW'(DEPTH));

  a_wb_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (wb_valid_o && !wb_ready_i && !flush_i) |=> ($stable(wb_data_o) && $stable(wb_rd_o)));

  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    w_push |-> !w_full);

  // A result offered while full is lost; this marks the protocol violation.
  c_drop_when_full : cover property (@(posedge clk_i) disable iff (rst_i)
    multdiv_valid_i && w_full && !flush_i);

endmodule

// File: tb/tb_ibex_multdiv_imd_wb_buffer.sv
// Scoreboard bench for ibex_multdiv_imd_wb_buffer: stimulus queues expected results,
// a negedge monitor pops and compares each accepted writeback.
module tb_ibex_multdiv_imd_wb_buffer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned IMD_W = 34;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic [1:0][IMD_W-1:0] imd_val_d_i;
  logic [1:0]            imd_val_we_i;
  logic [1:0][IMD_W-1:0] imd_val_q_o;
  logic                  multdiv_valid_i;
  logic [31:0]           multdiv_result_i;
  logic [4:0]            multdiv_rd_i;
  logic                  multdiv_ready_id_o;
  logic                  wb_valid_o;
  logic [31:0]           wb_data_o;
  logic [4:0]            wb_rd_o;
  logic                  wb_ready_i;
  logic [CW-1:0]         count_o;
`ifdef MULTDIV_IMD_PARITY_EN
  logic                  imd_parity_err_o;
`endif

  ibex_multdiv_imd_wb_buffer #(
    .DEPTH (DEPTH),
    .IMD_W (IMD_W)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .imd_val_d_i        (imd_val_d_i),
    .imd_val_we_i       (imd_val_we_i),
    .imd_val_q_o        (imd_val_q_o),
    .multdiv_valid_i    (multdiv_valid_i),
    .multdiv_result_i   (multdiv_result_i),
    .multdiv_rd_i       (multdiv_rd_i),
    .multdiv_ready_id_o (multdiv_ready_id_o),
    .wb_valid_o         (wb_valid_o),
    .wb_data_o          (wb_data_o),
    .wb_rd_o            (wb_rd_o),
    .wb_ready_i         (wb_ready_i),
    .count_o            (count_o)
`ifdef MULTDIV_IMD_PARITY_EN
    ,
    .imd_parity_err_o   (imd_parity_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [36:0] sb[$];  // {rd, data}

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] data, input logic [4:0] rd, input bit accepted);
    multdiv_valid_i  = 1'b1;
    multdiv_result_i = data;
    multdiv_rd_i     = rd;
    if (accepted) sb.push_back({rd, data});
  endtask

  // Monitor: each accepted writeback must match the oldest queued result.
  always @(negedge clk_i) begin
    if (!rst_i && wb_valid_o && wb_ready_i && !flush_i) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wb_unexpected: got data %0h rd %0d with empty scoreboard", wb_data_o,
                 wb_rd_o);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        check("wb_data", 128'(wb_data_o), 128'(e[31:0]));
        check("wb_rd", 128'(wb_rd_o), 128'(e[36:32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i            = 1'b1;
    flush_i          = 1'b0;
    imd_val_d_i      = '0;
    imd_val_we_i     = '0;
    multdiv_valid_i  = 1'b0;
    multdiv_result_i = '0;
    multdiv_rd_i     = '0;
    wb_ready_i       = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check("rst_imd", 128'(imd_val_q_o), 128'(0));
    check("rst_count", 128'(count_o), 128'(0));
    check("rst_wb_valid", 128'(wb_valid_o), 128'(0));
    check("rst_ready", 128'(multdiv_ready_id_o), 128'(1));

    // Independent imd register writes.
    imd_val_we_i   = 2'b01;
    imd_val_d_i[0] = 34'h2_DEAD_BEEF;
    tick();
    imd_val_we_i   = 2'b10;
    imd_val_d_i[0] = 34'h0_1234_5678;
    imd_val_d_i[1] = 34'h1_0000_0001;
    tick();
    imd_val_we_i = 2'b00;
    check("imd_q0", 128'(imd_val_q_o[0]), 128'(34'h2_DEAD_BEEF));
    check("imd_q1", 128'(imd_val_q_o[1]), 128'(34'h1_0000_0001));

    // Fill, drop when full, then drain.
    issue(32'h11, 5'd5, 1'b1);
    tick();
    check("lat1_valid", 128'(wb_valid_o), 128'(1));
    issue(32'h22, 5'd6, 1'b1);
    tick();
    multdiv_valid_i = 1'b0;
    check("full_count", 128'(count_o), 128'(2));
    check("full_ready", 128'(multdiv_ready_id_o), 128'(0));
    check("full_head", 128'(wb_data_o), 128'(32'h11));
    issue(32'h33, 5'd7, 1'b0);
    tick();
    multdiv_valid_i = 1'b0;
    check("drop_count", 128'(count_o), 128'(2));
    wb_ready_i = 1'b1;
    tick();
    tick();
    wb_ready_i = 1'b0;
    check("drain_count", 128'(count_o), 128'(0));
    check("drain_ready", 128'(multdiv_ready_id_o), 128'(1));

    // Steady state push+pop at occupancy 1, wrapping the pointers.
    issue(32'hAA, 5'd1, 1'b1);
    tick();
    wb_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(32'hB0 + 32'(i), 5'(8 + i), 1'b1);
      tick();
      check("pp_count", 128'(count_o), 128'(1));
    end
    multdiv_valid_i = 1'b0;
    tick();
    wb_ready_i = 1'b0;
    check("pp_drained", 128'(count_o), 128'(0));
    check("pp_sb_empty", 128'(sb.size()), 128'(0));

    // Flush with push and imd write in the same cycle.
    issue(32'hCC, 5'd3, 1'b1);
    tick();
    check("pre_flush_count", 128'(count_o), 128'(1));
    issue(32'hDD, 5'd4, 1'b0);
    imd_val_we_i = 2'b11;
    imd_val_d_i  = '1;
    flush_i      = 1'b1;
    tick();
    flush_i         = 1'b0;
    multdiv_valid_i = 1'b0;
    imd_val_we_i    = 2'b00;
    sb.delete();
    check("flush_count", 128'(count_o), 128'(0));
    check("flush_wb_valid", 128'(wb_valid_o), 128'(0));
    check("flush_imd", 128'(imd_val_q_o), 128'(0));
    check("flush_ready", 128'(multdiv_ready_id_o), 128'(1));
    issue(32'hEE, 5'd9, 1'b1);
    tick();
    multdiv_valid_i = 1'b0;
    check("post_flush_valid", 128'(wb_valid_o), 128'(1));
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    check("post_flush_count", 128'(count_o), 128'(0));

    // Asynchronous reset mid-operation.
    issue(32'hFF, 5'd2, 1'b1);
    imd_val_we_i   = 2'b01;
    imd_val_d_i[0] = 34'h3_0000_0003;
    tick();
    multdiv_valid_i = 1'b0;
    imd_val_we_i    = 2'b00;
    rst_i = 1'b1;
    #1;
    check("arst_count", 128'(count_o), 128'(0));
    check("arst_wb_valid", 128'(wb_valid_o), 128'(0));
    check("arst_imd", 128'(imd_val_q_o), 128'(0));
    sb.delete();
    rst_i = 1'b0;
    tick();
    check("arst_ready", 128'(multdiv_ready_id_o), 128'(1));

`ifdef MULTDIV_IMD_PARITY_EN
    imd_val_we_i   = 2'b01;
    imd_val_d_i[0] = 34'h0_0000_0001;
    tick();
    imd_val_we_i = 2'b00;
    tick();
    check("par_clean", 128'(imd_parity_err_o), 128'(0));
    force dut.r_imd[0][1] = 1'b1;
    tick();
    release dut.r_imd[0][1];
    check("par_err", 128'(imd_parity_err_o), 128'(1));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("par_flush", 128'(imd_parity_err_o), 128'(0));
`endif

    tick();
    check("final_sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
